cache_miss_fsm: RTL and testbench

//  Parametrised miss-handling controller for the direct-mapped, one-word-line data cache beside the MIPS core.

---
 rtl/cache_pkg.sv | 23 ++
 rtl/sat_counter.sv | 31 +++
 rtl/cache_miss_fsm.sv | 198 +++++++++++++++++++
 tb/tb_cache_miss_fsm.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types for the data-cache miss controller: FSM states, write-policy codes
// and the request descriptor that is latched on a miss.
package cache_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WB      = 3'd1,
      FILL    = 3'd2,
      FILL_WR = 3'd3,
      WSTORE  = 3'd4,
      RESP    = 3'd5,
      WT      = 3'd6
   } state_t;

   localparam int WB_POLICY = 0;
   localparam int WT_POLICY = 1;

   typedef struct packed {
      logic rd;
      logic byte_acc;
   } op_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && !(&cnt_q)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/cache_miss_fsm.sv
// Miss-handling controller for a direct-mapped, one-word-line data cache:
// sequences write-back, fill and write-through traffic over a req/ack memory port.
module cache_miss_fsm
   import cache_pkg::*;
#(
   parameter int WRITE_POLICY = 0,
   parameter int TIMEOUT      = 0,
   parameter int TO_W         = 8,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cpu_rd,
   input  logic             cpu_wr,
   input  logic             cpu_byte,
   input  logic             cache_hit,
   input  logic             cache_dirty,
   input  logic             mem_ack,
   output logic             stall,
   output logic             rf_we,
   output logic             cache_we,
   output logic             fill_sel,
   output logic             set_valid,
   output logic             set_dirty,
   output logic             mem_addr_sel,
   output logic             mem_req,
   output logic             mem_we,
   output logic             timeout_err,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt,
   output logic [CNT_W-1:0] wb_cnt
);

   localparam int              TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_LAST_I);
   localparam logic            IS_WB     = (WRITE_POLICY == WB_POLICY);

   state_t          state_q, state_d;
   op_t             op_q, op_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            timeout_err_q, timeout_err_d;

   logic req_rd, req_wr, req, wait_st, to_abort;

   // Requests are masked during reset so every output is forced low while rst_n is asserted.
   // A simultaneous rd/wr is resolved as a read.
   assign req_rd   = rst_n & cpu_rd;
   assign req_wr   = rst_n & cpu_wr & ~cpu_rd;
   assign req      = req_rd | req_wr;
   assign wait_st  = (state_q == WB) || (state_q == FILL) || (state_q == WT);
   assign to_abort = (TIMEOUT > 0) && wait_st && !mem_ack && (to_cnt_q == TO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         op_q          <= '0;
         to_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         to_cnt_q      <= to_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      case (state_q)
         IDLE: begin
            if (req && cache_hit) begin
               if (req_wr && !IS_WB) state_d = WT;
            end else if (req) begin
               op_d.rd       = req_rd;
               op_d.byte_acc = cpu_byte;
               if (IS_WB) begin
                  if (cache_dirty)              state_d = WB;
                  else if (req_rd || cpu_byte)  state_d = FILL;
               end else begin
                  state_d = req_rd ? FILL : WT;
               end
            end
         end
         WB: begin
            if (mem_ack)       state_d = (op_q.rd || op_q.byte_acc) ? FILL : WSTORE;
            else if (to_abort) state_d = IDLE;
         end
         FILL: begin
            if (mem_ack)       state_d = FILL_WR;
            else if (to_abort) state_d = IDLE;
         end
         FILL_WR: state_d = op_q.rd ? RESP : WSTORE;
         WSTORE:  state_d = IDLE;
         RESP:    state_d = IDLE;
         WT: begin
            if (mem_ack || to_abort) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Counter restarts on every state change, so each wait state gets a fresh budget.
      if (state_d != state_q)        to_cnt_d = '0;
      else if (wait_st && !mem_ack)  to_cnt_d = to_cnt_q + TO_W'(1);
      else                           to_cnt_d = to_cnt_q;

      timeout_err_d = timeout_err_q | to_abort;
   end

   always_comb begin
      stall        = 1'b0;
      rf_we        = 1'b0;
      cache_we     = 1'b0;
      fill_sel     = 1'b0;
      set_valid    = 1'b0;
      set_dirty    = 1'b0;
      mem_addr_sel = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      case (state_q)
         IDLE: begin
            if (req && cache_hit) begin
               if (req_rd) begin
                  rf_we = 1'b1;
               end else begin
                  cache_we  = 1'b1;
                  fill_sel  = 1'b1;
                  set_valid = 1'b1;
                  set_dirty = IS_WB;
                  stall     = !IS_WB;
               end
            end else if (req) begin
               stall = 1'b1;
               // Clean word-store miss overwrites the whole line, so no fetch is needed.
               if (IS_WB && !cache_dirty && req_wr && !cpu_byte) begin
                  cache_we  = 1'b1;
                  fill_sel  = 1'b1;
                  set_valid = 1'b1;
                  set_dirty = 1'b1;
                  stall     = 1'b0;
               end
            end
         end
         WB: begin
            mem_req      = 1'b1;
            mem_we       = 1'b1;
            mem_addr_sel = 1'b1;
            stall        = !to_abort;
         end
         FILL: begin
            mem_req = 1'b1;
            stall   = !to_abort;
         end
         FILL_WR: begin
            cache_we  = 1'b1;
            set_valid = 1'b1;
            stall     = 1'b1;
         end
         WSTORE: begin
            cache_we  = 1'b1;
            fill_sel  = 1'b1;
            set_valid = 1'b1;
            set_dirty = 1'b1;
         end
         RESP: rf_we = 1'b1;
         WT: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            stall   = !mem_ack && !to_abort;
         end
         default: ;
      endcase
   end

   assign timeout_err = timeout_err_q;

   sat_counter #(.W(CNT_W)) u_hit_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   ((state_q == IDLE) && req && cache_hit),
      .count (hit_cnt)
   );

   sat_counter #(.W(CNT_W)) u_miss_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   ((state_q == IDLE) && req && !cache_hit),
      .count (miss_cnt)
   );

   sat_counter #(.W(CNT_W)) u_wb_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   ((state_q == WB) && mem_ack),
      .count (wb_cnt)
   );

endmodule

// File: tb/tb_cache_miss_fsm.sv
// Bench for cache_miss_fsm: two instances (write-back with TIMEOUT=4, write-through with
// 2-bit counters) driven by directed and random requests against a transaction-level model.
module tb_cache_miss_fsm;
   import cache_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n       [2];
   logic cpu_rd      [2];
   logic cpu_wr      [2];
   logic cpu_byte    [2];
   logic cache_hit   [2];
   logic cache_dirty [2];
   logic mem_ack     [2];
   logic stall       [2];
   logic rf_we       [2];
   logic cache_we    [2];
   logic fill_sel    [2];
   logic set_valid   [2];
   logic set_dirty   [2];
   logic mem_addr_sel[2];
   logic mem_req     [2];
   logic mem_we      [2];
   logic timeout_err [2];
   logic [15:0] hc0, mc0, wc0;
   logic [1:0]  hc1, mc1, wc1;

   cache_miss_fsm #(.WRITE_POLICY(0), .TIMEOUT(4), .TO_W(8), .CNT_W(16)) dut_wb (
      .clk(clk), .rst_n(rst_n[0]), .cpu_rd(cpu_rd[0]), .cpu_wr(cpu_wr[0]),
      .cpu_byte(cpu_byte[0]), .cache_hit(cache_hit[0]), .cache_dirty(cache_dirty[0]),
      .mem_ack(mem_ack[0]), .stall(stall[0]), .rf_we(rf_we[0]), .cache_we(cache_we[0]),
      .fill_sel(fill_sel[0]), .set_valid(set_valid[0]), .set_dirty(set_dirty[0]),
      .mem_addr_sel(mem_addr_sel[0]), .mem_req(mem_req[0]), .mem_we(mem_we[0]),
      .timeout_err(timeout_err[0]), .hit_cnt(hc0), .miss_cnt(mc0), .wb_cnt(wc0)
   );

   cache_miss_fsm #(.WRITE_POLICY(1), .TIMEOUT(0), .TO_W(8), .CNT_W(2)) dut_wt (
      .clk(clk), .rst_n(rst_n[1]), .cpu_rd(cpu_rd[1]), .cpu_wr(cpu_wr[1]),
      .cpu_byte(cpu_byte[1]), .cache_hit(cache_hit[1]), .cache_dirty(cache_dirty[1]),
      .mem_ack(mem_ack[1]), .stall(stall[1]), .rf_we(rf_we[1]), .cache_we(cache_we[1]),
      .fill_sel(fill_sel[1]), .set_valid(set_valid[1]), .set_dirty(set_dirty[1]),
      .mem_addr_sel(mem_addr_sel[1]), .mem_req(mem_req[1]), .mem_we(mem_we[1]),
      .timeout_err(timeout_err[1]), .hit_cnt(hc1), .miss_cnt(mc1), .wb_cnt(wc1)
   );

   int checks   = 0;
   int failures = 0;
   int exp_hit [2];
   int exp_miss[2];
   int exp_wb  [2];
   bit exp_terr[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] hitc(input int d);
      return (d == 0) ? 32'(hc0) : 32'(hc1);
   endfunction
   function automatic logic [31:0] missc(input int d);
      return (d == 0) ? 32'(mc0) : 32'(mc1);
   endfunction
   function automatic logic [31:0] wbc(input int d);
      return (d == 0) ? 32'(wc0) : 32'(wc1);
   endfunction
   function automatic logic [31:0] sat(input int v, input int d);
      int mx;
      mx = (d == 0) ? 65535 : 3;
      return (v > mx) ? mx : v;
   endfunction

   task automatic clear_inputs(input int d);
      cpu_rd[d] = 0; cpu_wr[d] = 0; cpu_byte[d] = 0;
      cache_hit[d] = 0; cache_dirty[d] = 0; mem_ack[d] = 0;
   endtask

   task automatic clear_model(input int d);
      exp_hit[d] = 0; exp_miss[d] = 0; exp_wb[d] = 0; exp_terr[d] = 0;
   endtask

   task automatic chk_quiet(input int d);
      chk("rst_stall", stall[d], 0);      chk("rst_rf_we", rf_we[d], 0);
      chk("rst_cache_we", cache_we[d], 0); chk("rst_mem_req", mem_req[d], 0);
      chk("rst_mem_we", mem_we[d], 0);     chk("rst_terr", timeout_err[d], 0);
      chk("rst_hit_cnt", hitc(d), 0);      chk("rst_miss_cnt", missc(d), 0);
      chk("rst_wb_cnt", wbc(d), 0);
   endtask

   // One CPU request from issue to the cycle stall drops; l1/l2 are ack latencies of the
   // first/second memory transfer (ack in the Nth request cycle, 0 = never).
   task automatic run_txn(input int d, input bit rd, input bit wr, input bit by,
                          input bit hit, input bit dirty, input int l1, input int l2);
      bit is_wb, wre, req, xrf, aborted, done, acked;
      int t, total, tail, run, cyc, ost, orf, orfc;
      int xl[$]; bit xw[$]; bit xa[$]; logic [2:0] xcw[$]; logic [2:0] post[$];
      int ol[$]; bit ow[$]; bit oa[$]; logic [2:0] ocw[$];

      // ---- expectation from the controller's rules ----
      is_wb = (d == 0); t = is_wb ? 4 : 0;
      wre = wr & ~rd; req = rd | wre;
      xrf = 0; aborted = 0; total = 1; tail = 0;
      if (req && hit) begin
         exp_hit[d]++;
         if (rd) xrf = 1;
         else begin
            xcw.push_back({1'b1, 1'b1, is_wb});
            if (!is_wb) begin xw.push_back(1); xa.push_back(0); end
         end
      end else if (req) begin
         exp_miss[d]++;
         if (is_wb) begin
            if (!dirty && wre && !by) xcw.push_back(3'b111);
            else begin
               if (dirty) begin xw.push_back(1); xa.push_back(1); end
               if (rd || by) begin xw.push_back(0); xa.push_back(0); post.push_back(3'b010); tail++; end
               if (wre) begin post.push_back(3'b111); tail++; end
               if (rd) begin xrf = 1; tail++; end
            end
         end else if (rd) begin
            xw.push_back(0); xa.push_back(0); post.push_back(3'b010); tail += 2; xrf = 1;
         end else begin
            xw.push_back(1); xa.push_back(0);
         end
      end
      for (int i = 0; i < xw.size() && !aborted; i++) begin
         int l;
         l = (i == 0) ? l1 : l2;
         if (t > 0 && (l == 0 || l > t)) begin
            aborted = 1; xl.push_back(t); total += t;
         end else begin
            xl.push_back(l); total += l;
            if (xw[i] && xa[i]) exp_wb[d]++;
         end
      end
      while (xw.size() > xl.size()) begin void'(xw.pop_back()); void'(xa.pop_back()); end
      if (aborted) begin xrf = 0; exp_terr[d] = 1; end
      else begin total += tail; foreach (post[i]) xcw.push_back(post[i]); end

      // ---- drive and observe ----
      cpu_rd[d] = rd; cpu_wr[d] = wr; cpu_byte[d] = by;
      cache_hit[d] = hit; cache_dirty[d] = dirty; mem_ack[d] = 0;
      done = 0; acked = 0; run = 0; cyc = 0; ost = 0; orf = 0; orfc = -1;
      while (!done && cyc < 100) begin
         if (acked) run = 0;
         if (mem_req[d]) begin
            if (run == 0) begin ow.push_back(mem_we[d]); oa.push_back(mem_addr_sel[d]); ol.push_back(0); end
            run++;
            ol[ol.size()-1] = run;
            mem_ack[d] = (run == ((ol.size() == 1) ? l1 : l2));
         end else begin
            run = 0; mem_ack[d] = 0;
         end
         acked = mem_ack[d];
         @(negedge clk);
         if (stall[d]) ost++; else done = 1;
         if (rf_we[d]) begin orf++; orfc = cyc; end
         if (cache_we[d]) ocw.push_back({fill_sel[d], set_valid[d], set_dirty[d]});
         cyc++;
         @(posedge clk); #1;
      end
      clear_inputs(d);

      $display("txn dut=%0d rd=%0d wr=%0d byte=%0d hit=%0d dirty=%0d lat=%0d/%0d cycles=%0d stall=%0d exp_stall=%0d",
               d, rd, wr, by, hit, dirty, l1, l2, cyc, ost, total - 1);
      chk("txn_done", done, 1);
      chk("stall_cycles", ost, total - 1);
      chk("rf_we_pulses", orf, xrf);
      if (xrf) chk("rf_we_cycle", orfc, total - 1);
      chk("cache_writes", ocw.size(), xcw.size());
      for (int i = 0; i < ocw.size() && i < xcw.size(); i++) chk("cache_write_flags", ocw[i], xcw[i]);
      chk("mem_bursts", ol.size(), xl.size());
      for (int i = 0; i < ol.size() && i < xl.size(); i++) begin
         chk("burst_len", ol[i], xl[i]);
         chk("burst_we", ow[i], xw[i]);
         chk("burst_addr_sel", oa[i], xa[i]);
      end
      chk("hit_cnt", hitc(d), sat(exp_hit[d], d));
      chk("miss_cnt", missc(d), sat(exp_miss[d], d));
      chk("wb_cnt", wbc(d), sat(exp_wb[d], d));
      chk("timeout_err", timeout_err[d], exp_terr[d]);
      chk("idle_mem_req", mem_req[d], 0);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin rst_n[d] = 0; clear_inputs(d); clear_model(d); end
      @(posedge clk); #1;
      chk_quiet(0); chk_quiet(1);
      @(posedge clk); #1;
      rst_n[0] = 1; rst_n[1] = 1;
      @(posedge clk); #1;

      // write-back instance, TIMEOUT=4
      run_txn(0, 1, 0, 0, 1, 0, 0, 0);   // read hit
      run_txn(0, 1, 0, 0, 0, 1, 3, 3);   // dirty read miss, 3-cycle memory
      run_txn(0, 0, 1, 1, 0, 0, 2, 0);   // clean byte-store miss
      run_txn(0, 0, 1, 0, 0, 0, 0, 0);   // clean word-store miss, no fetch
      run_txn(0, 0, 1, 0, 0, 1, 1, 0);   // dirty word-store miss
      run_txn(0, 0, 1, 1, 0, 1, 2, 1);   // dirty byte-store miss
      run_txn(0, 0, 1, 0, 1, 0, 0, 0);   // write hit
      run_txn(0, 1, 0, 0, 0, 0, 1, 0);   // zero-wait clean read miss
      run_txn(0, 1, 1, 0, 1, 0, 0, 0);   // rd+wr together behaves as read
      run_txn(0, 1, 0, 0, 0, 0, 4, 0);   // ack on the last allowed cycle
      run_txn(0, 1, 0, 0, 0, 0, 0, 0);   // no ack: timeout in FILL
      run_txn(0, 1, 0, 0, 0, 1, 3, 5);   // timeout in second transfer
      for (int i = 0; i < 20; i++)
         run_txn(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 5), $urandom_range(0, 5));

      // write-through instance, CNT_W=2
      run_txn(1, 0, 1, 0, 1, 0, 3, 0);   // word-store hit then write-through
      run_txn(1, 0, 1, 0, 0, 1, 1, 0);   // store miss, no allocate
      run_txn(1, 1, 0, 0, 0, 0, 2, 0);   // read miss fill
      for (int i = 0; i < 15; i++) begin
         bit r;
         r = 1'($urandom_range(0, 1));
         run_txn(1, r, !r, $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(1, 4), $urandom_range(1, 4));
      end

      // reset while waiting in FILL
      cpu_rd[1] = 1; cache_hit[1] = 0; mem_ack[1] = 0;
      exp_miss[1]++;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("fill_mem_req", mem_req[1], 1);
      chk("fill_stall", stall[1], 1);
      chk("fill_miss_cnt", missc(1), sat(exp_miss[1], 1));
      #3 rst_n[1] = 0;
      #1;
      $display("reset mid-fill dut=1 mem_req=%0d stall=%0d", mem_req[1], stall[1]);
      chk("async_rst_mem_req", mem_req[1], 0);
      chk("async_rst_stall", stall[1], 0);
      chk("async_rst_rf_we", rf_we[1], 0);
      chk("async_rst_miss_cnt", missc(1), 0);
      clear_inputs(1); clear_model(1);
      @(posedge clk); #1;
      rst_n[1] = 1;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) run_txn(1, 1, 0, 0, 1, 0, 0, 0);
      chk("hit_cnt_saturated", hitc(1), 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
